// File: rtl/vpu_pkg.sv
// ============================================================================
//  Module   : vpu_pkg
//  Purpose  : Shared constants for the VPU issue/lane datapath.
//             VPU_DATA_W : operand word width
//             LANE_A/B   : lane select encoding used by the steering logic
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vpu_pkg;

    localparam int VPU_DATA_W = 32;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

endpackage : vpu_pkg

`default_nettype wire

// File: rtl/vpu_lane_fifo.sv
// ============================================================================
//  Module   : vpu_lane_fifo
//  Purpose  : Single-lane FIFO with registered storage and combinational head.
//  Ports    : clk, rst_n      clock, async active-low reset
//             flush           synchronous clear of pointers/count
//             push, push_data write request (caller guarantees not full)
//             pop             consumer takes head (ignored when empty)
//             valid           head present (count != 0)
//             head_data       storage[rd_ptr]
//             count           occupancy, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vpu_lane_fifo #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push_fire;
    logic w_pop_fire;

    // Push is re-qualified with full so the FIFO cannot be corrupted even if
    // a caller misbehaves; pop is only honoured while a head exists.
    assign w_push_fire = push && (r_count != c_depth);
    assign w_pop_fire  = pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_fire) begin
                r_mem[r_wr_ptr] <= push_data;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid     = (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : vpu_lane_fifo

`default_nettype wire

// File: rtl/vec_demux_1x2.sv
// ============================================================================
//  Module   : vec_demux_1x2
//  Purpose  : Stream-level 1-to-2 demultiplexer. Each accepted input word is
//             steered to lane A (in_sel=0) or lane B (in_sel=1); each lane is
//             buffered by its own FIFO so a stalled lane never blocks the other.
//  Ports    : clk, rst_n               clock, async active-low reset
//             flush                    synchronous clear of both lanes
//             in_valid/in_ready/in_sel/in_data   input stream
//             a_valid/a_ready/a_data/a_count     lane A output
//             b_valid/b_ready/b_data/b_count     lane B output
//  Config   : VDMX_BCAST_EN adds in_bcast; when set the word is pushed into
//             both lanes at the same edge (accepted only if neither is full).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_demux_1x2
    import vpu_pkg::*;
#(
    parameter int  DATA_W = VPU_DATA_W,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
`ifdef VDMX_BCAST_EN
    input  logic              in_bcast,
`endif
    input  logic [DATA_W-1:0] in_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] a_data,
    output logic [CNT_W-1:0]  a_count,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [DATA_W-1:0] b_data,
    output logic [CNT_W-1:0]  b_count
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic w_full_a;
    logic w_full_b;
    logic w_to_a;
    logic w_to_b;
    logic w_accept;

    assign w_full_a = (a_count == c_depth);
    assign w_full_b = (b_count == c_depth);

`ifdef VDMX_BCAST_EN
    assign w_to_a = in_bcast || (in_sel == LANE_A);
    assign w_to_b = in_bcast || (in_sel == LANE_B);
`else
    assign w_to_a = (in_sel == LANE_A);
    assign w_to_b = (in_sel == LANE_B);
`endif

    // Ready looks only at the fullness of the destination lane(s) as registered
    // at this cycle; a same-cycle pop does not open a slot. rst_n is folded in
    // so nothing is offered as accepted while reset is held.
    assign in_ready = rst_n && !flush
                      && !(w_to_a && w_full_a)
                      && !(w_to_b && w_full_b);

    assign w_accept = in_valid && in_ready;

    vpu_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_accept && w_to_a),
        .push_data (in_data),
        .pop       (a_ready),
        .valid     (a_valid),
        .head_data (a_data),
        .count     (a_count)
    );

    vpu_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_accept && w_to_b),
        .push_data (in_data),
        .pop       (b_ready),
        .valid     (b_valid),
        .head_data (b_data),
        .count     (b_count)
    );

endmodule : vec_demux_1x2

`default_nettype wire

// File: tb/tb_vec_demux_1x2.sv
// ============================================================================
//  Module   : tb_vec_demux_1x2
//  Purpose  : Self-checking bench for vec_demux_1x2 (queue-based lane model
//             plus directed literal expectations).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vec_demux_1x2;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sel = 1'b0;
    logic        in_bcast = 1'b0;
    logic [31:0] in_data = '0;
    logic        a_valid, b_valid;
    logic        a_ready = 1'b0, b_ready = 1'b0;
    logic [31:0] a_data, b_data;
    logic [2:0]  a_count, b_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] ga[$];
    logic [31:0] gb[$];
    logic        cap_en = 1'b0;

    vec_demux_1x2 #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
`ifdef VDMX_BCAST_EN
        .in_bcast (in_bcast),
`endif
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: destination set from sel/bcast, reject on full.
    function automatic logic model_bcast();
`ifdef VDMX_BCAST_EN
        return in_bcast;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_ready();
        logic to_a, to_b;
        to_a = model_bcast() || (in_sel == 1'b0);
        to_b = model_bcast() || (in_sel == 1'b1);
        if (!rst_n || flush) return 1'b0;
        if (to_a && qa.size() >= DEPTH) return 1'b0;
        if (to_b && qb.size() >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            logic acc;
            acc = in_valid && model_ready();
            if (cap_en && a_ready && qa.size() > 0) ga.push_back(qa[0]);
            if (cap_en && b_ready && qb.size() > 0) gb.push_back(qb[0]);
            if (a_ready && qa.size() > 0) void'(qa.pop_front());
            if (b_ready && qb.size() > 0) void'(qb.pop_front());
            if (acc && (model_bcast() || in_sel == 1'b0)) qa.push_back(in_data);
            if (acc && (model_bcast() || in_sel == 1'b1)) qb.push_back(in_data);
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
            check("a_count", {61'd0, a_count}, 64'(qa.size()));
            check("b_count", {61'd0, b_count}, 64'(qb.size()));
            check("a_valid", {63'd0, a_valid}, {63'd0, qa.size() != 0});
            check("b_valid", {63'd0, b_valid}, {63'd0, qb.size() != 0});
            if (qa.size() != 0) check("a_data", {32'd0, a_data}, {32'd0, qa[0]});
            if (qb.size() != 0) check("b_data", {32'd0, b_data}, {32'd0, qb[0]});
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst a_valid", {63'd0, a_valid}, 64'd0);
        check("rst b_valid", {63'd0, b_valid}, 64'd0);
        check("rst a_data", {32'd0, a_data}, 64'd0);
        check("rst counts", {58'd0, a_count, b_count}, 64'd0);
        check("rst in_ready", {63'd0, in_ready}, 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc();

        // 1: single push to A
        push(1'b0, 32'hA5A5_0001);
        check("t1 a_valid", {63'd0, a_valid}, 64'd1);
        check("t1 a_data", {32'd0, a_data}, 64'hA5A5_0001);
        check("t1 a_count", {61'd0, a_count}, 64'd1);
        check("t1 b_valid", {63'd0, b_valid}, 64'd0);

        // 2: fill A with a_ready=0, B still open
        push(1'b0, 32'h2);
        push(1'b0, 32'h3);
        push(1'b0, 32'h4);
        check("t2 a_count", {61'd0, a_count}, 64'd4);
        in_sel = 1'b0; #1;
        check("t2 ready sel0", {63'd0, in_ready}, 64'd0);
        in_sel = 1'b1; #1;
        check("t2 ready sel1", {63'd0, in_ready}, 64'd1);
        push(1'b1, 32'h0000_00BB);
        check("t2 b_data", {32'd0, b_data}, 64'hBB);
        check("t2 a_data held", {32'd0, a_data}, 64'hA5A5_0001);

        // 3: full A, pop and push same cycle -> push rejected
        a_ready  = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_0005;
        #1;
        check("t3 in_ready", {63'd0, in_ready}, 64'd0);
        cyc();
        in_valid = 1'b0; a_ready = 1'b0;
        check("t3 a_count", {61'd0, a_count}, 64'd3);
        check("t3 a_data", {32'd0, a_data}, 64'h2);

        // drain
        a_ready = 1'b1; b_ready = 1'b1;
        cyc(5);
        check("drain counts", {58'd0, a_count, b_count}, 64'd0);

        // 4: alternating stream, both lanes consuming
        cap_en = 1'b1;
        for (int i = 0; i < 10; i++) push(i[0], 32'h100 + 32'(i));
        cyc(3);
        cap_en = 1'b0;
        check("t4 ga size", 64'(ga.size()), 64'd5);
        check("t4 gb size", 64'(gb.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < ga.size()) check("t4 ga word", {32'd0, ga[k]}, 64'(32'h100 + 32'(2 * k)));
            if (k < gb.size()) check("t4 gb word", {32'd0, gb[k]}, 64'(32'h101 + 32'(2 * k)));
        end

        // 5: flush wins over push
        a_ready = 1'b0; b_ready = 1'b0;
        push(1'b0, 32'h51); push(1'b0, 32'h52);
        push(1'b1, 32'h61); push(1'b1, 32'h62);
        check("t5 pre counts", {58'd0, a_count, b_count}, {58'd0, 3'd2, 3'd2});
        flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77;
        #1;
        check("t5 in_ready", {63'd0, in_ready}, 64'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("t5 counts", {58'd0, a_count, b_count}, 64'd0);
        check("t5 valids", {62'd0, a_valid, b_valid}, 64'd0);

`ifdef VDMX_BCAST_EN
        // 6: broadcast blocked by full B, then accepted into both lanes
        for (int i = 0; i < 4; i++) push(1'b1, 32'hB0 + 32'(i));
        in_bcast = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1234_5678;
        #1;
        check("t6 blocked", {63'd0, in_ready}, 64'd0);
        cyc();
        check("t6 a unchanged", {61'd0, a_count}, 64'd0);
        b_ready = 1'b1;
        cyc();
        b_ready = 1'b0;
        #1;
        check("t6 ready", {63'd0, in_ready}, 64'd1);
        cyc();
        in_valid = 1'b0; in_bcast = 1'b0;
        check("t6 a_data", {32'd0, a_data}, 64'h1234_5678);
        b_ready = 1'b1;
        cyc(3);
        b_ready = 1'b0;
        check("t6 b_data", {32'd0, b_data}, 64'h1234_5678);
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
`endif

        // Async reset mid-transfer loses queued words immediately
        push(1'b0, 32'h99); push(1'b1, 32'h98);
        #3;
        rst_n = 1'b0;
        #1;
        check("async a_valid", {63'd0, a_valid}, 64'd0);
        check("async counts", {58'd0, a_count, b_count}, 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vec_demux_1x2

`default_nettype wire
